// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite master bridge and its peripherals:
//   - AXI response codes
//   - bridge FSM state encoding
//   - encoder_axi register map and CTRL bit positions
//   - helper that sizes the optional handshake timeout counter
// -----------------------------------------------------------------------------
package axil_pkg;

  // AXI4-Lite response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bridge FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WR_REQ  = ST_WR_REQ,
    WR_RESP = ST_WR_RESP,
    RD_REQ  = ST_RD_REQ,
    RD_RESP = ST_RD_RESP,
    RSP     = ST_RSP
  } state_t;

  // encoder_axi register offsets
  localparam logic [31:0] ENC_CTRL     = 32'h0000_0000;
  localparam logic [31:0] ENC_STATUS   = 32'h0000_0004;
  localparam logic [31:0] ENC_POSITION = 32'h0000_0008;

  // encoder_axi CTRL bit positions
  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_CLR_POS = 1;

  // Timeout counter width: enough for the limit, never narrower than 8 bits.
  function automatic int timer_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// -----------------------------------------------------------------------------
// axil_master_bridge
// Single-outstanding AXI4-Lite initiator. A valid/ready command (read or
// write) is turned into one AXI4-Lite transaction; the B/R result is returned
// on a valid/ready response port. Reads and writes are strictly serialised.
//
// Optional feature macro: AXIL_TIMEOUT_EN
//   defined   : each slave handshake is bounded by TIMEOUT_CYC cycles; on
//               expiry the transaction is aborted with rsp_resp = 2'b11,
//               rsp_data = 0 and rsp_timeout = 1.
//   undefined : the bridge waits indefinitely; rsp_timeout is tied to 0.
//
// Ports:
//   aclk, areset             clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready only high in IDLE)
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_wstrb     command payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_resp,
//   rsp_timeout              response payload (rsp_data = 0 for writes)
//   m_axi_aw*/w*/b*/ar*/r*   AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  state_t state_r;
  logic   aw_done_r;
  logic   w_done_r;

  logic   aw_hs_s;
  logic   w_hs_s;
  logic   both_done_s;
  logic   advance_s;
  logic   wait_s;

  assign aw_hs_s     = m_axi_awvalid & m_axi_awready;
  assign w_hs_s      = m_axi_wvalid  & m_axi_wready;
  // Write address and data may complete in either order or together.
  assign both_done_s = (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);

  // Decode whether the FSM is waiting on the slave and whether it moves on.
  always_comb begin
    wait_s    = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      WR_REQ: begin
        wait_s    = 1'b1;
        advance_s = both_done_s;
      end
      WR_RESP: begin
        wait_s    = 1'b1;
        advance_s = m_axi_bvalid & m_axi_bready;
      end
      RD_REQ: begin
        wait_s    = 1'b1;
        advance_s = m_axi_arvalid & m_axi_arready;
      end
      RD_RESP: begin
        wait_s    = 1'b1;
        advance_s = m_axi_rvalid & m_axi_rready;
      end
      default: begin
        wait_s    = 1'b0;
        advance_s = 1'b0;
      end
    endcase
  end

`ifdef AXIL_TIMEOUT_EN
  localparam int TW = timer_width(TIMEOUT_CYC);

  logic [TW-1:0] timer_r;
  logic          timeout_r;
  logic          timeout_hit_s;

  // The counter holds TIMEOUT_CYC-1 in the last permitted cycle of a wait.
  assign timeout_hit_s = wait_s & (timer_r == TW'(TIMEOUT_CYC - 1));
  assign rsp_timeout   = timeout_r;

  // Per-state wait counter: cleared on every state entry.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      timer_r <= '0;
    end else if (wait_s && !advance_s && !timeout_hit_s) begin
      timer_r <= timer_r + 1'b1;
    end else begin
      timer_r <= '0;
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

  // Transaction sequencer; every AXI and response output is a register here.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r       <= IDLE;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_resp      <= 2'b00;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= 4'b0000;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
      timeout_r     <= 1'b0;
`endif
    end else begin
`ifdef AXIL_TIMEOUT_EN
      if (timeout_hit_s) begin
        // Abandon the slave handshake and report the abort.
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_data      <= '0;
        rsp_resp      <= RESP_DECERR;
        timeout_r     <= 1'b1;
        rsp_valid     <= 1'b1;
        state_r       <= RSP;
      end else
`endif
      begin
        case (state_r)
          IDLE: begin
            if (cmd_valid) begin
              cmd_ready <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
              timeout_r <= 1'b0;
`endif
              if (cmd_write) begin
                m_axi_awaddr  <= cmd_addr;
                m_axi_wdata   <= cmd_wdata;
                m_axi_wstrb   <= cmd_wstrb;
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                aw_done_r     <= 1'b0;
                w_done_r      <= 1'b0;
                state_r       <= WR_REQ;
              end else begin
                m_axi_araddr  <= cmd_addr;
                m_axi_arvalid <= 1'b1;
                state_r       <= RD_REQ;
              end
            end else begin
              cmd_ready <= 1'b1;
            end
          end
          WR_REQ: begin
            // Each channel retires independently on its own handshake.
            if (aw_hs_s) begin
              m_axi_awvalid <= 1'b0;
            end else begin
              m_axi_awvalid <= m_axi_awvalid;
            end
            if (w_hs_s) begin
              m_axi_wvalid <= 1'b0;
            end else begin
              m_axi_wvalid <= m_axi_wvalid;
            end
            aw_done_r <= aw_done_r | aw_hs_s;
            w_done_r  <= w_done_r  | w_hs_s;
            if (both_done_s) begin
              m_axi_bready <= 1'b1;
              state_r      <= WR_RESP;
            end else begin
              state_r      <= WR_REQ;
            end
          end
          WR_RESP: begin
            if (m_axi_bvalid && m_axi_bready) begin
              m_axi_bready <= 1'b0;
              rsp_resp     <= m_axi_bresp;
              rsp_data     <= '0;
              rsp_valid    <= 1'b1;
              state_r      <= RSP;
            end else begin
              state_r      <= WR_RESP;
            end
          end
          RD_REQ: begin
            if (m_axi_arvalid && m_axi_arready) begin
              m_axi_arvalid <= 1'b0;
              m_axi_rready  <= 1'b1;
              state_r       <= RD_RESP;
            end else begin
              state_r       <= RD_REQ;
            end
          end
          RD_RESP: begin
            if (m_axi_rvalid && m_axi_rready) begin
              m_axi_rready <= 1'b0;
              rsp_data     <= m_axi_rdata;
              rsp_resp     <= m_axi_rresp;
              rsp_valid    <= 1'b1;
              state_r      <= RSP;
            end else begin
              state_r      <= RD_RESP;
            end
          end
          RSP: begin
            // cmd_ready rises only after the response has been consumed.
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              cmd_ready <= 1'b1;
              state_r   <= IDLE;
            end else begin
              state_r   <= RSP;
            end
          end
          default: begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            cmd_ready     <= 1'b1;
            state_r       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axil_master_bridge.sv
`timescale 1ns/1ps
module tb_axil_master_bridge;
  import axil_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  int n_chk = 0, n_pass = 0;

  // Slave knobs
  int   aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic b_hold = 1'b0, ar_never = 1'b0;

  // encoder_axi-like slave state
  logic [31:0] ctrl_q, pos_q, aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_got, w_got;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        qa = 1'b0, qb = 1'b0;
  logic [1:0]  q_prev;
  logic [1:0]  gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int          qidx = 0;

  // Monitors
  int overlap_cnt = 0, aw_only_cnt = 0, b_hs_cnt = 0, ar_hi_cnt = 0;

  axil_master_bridge dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  function automatic logic fwd(input logic [1:0] p, input logic [1:0] c);
    return (p == 2'b00 && c == 2'b01) || (p == 2'b01 && c == 2'b11) ||
           (p == 2'b11 && c == 2'b10) || (p == 2'b10 && c == 2'b00);
  endfunction

  // Slave model: ready pulses one cycle (plus wait) after valid, B/R one cycle
  // after the completing handshake; registers as in encoder_axi.
  always @(posedge aclk or posedge areset) begin
    logic        aw_n, w_n;
    logic [31:0] a_addr, a_data;
    logic [3:0]  a_strb;
    if (areset) begin
      m_axi_awready <= 1'b0; m_axi_wready <= 1'b0; m_axi_arready <= 1'b0;
      m_axi_bvalid  <= 1'b0; m_axi_bresp  <= 2'b00;
      m_axi_rvalid  <= 1'b0; m_axi_rresp  <= 2'b00; m_axi_rdata <= 32'h0;
      ctrl_q <= 32'h0; pos_q <= 32'h0; aw_addr_q <= 32'h0; w_data_q <= 32'h0;
      w_strb_q <= 4'h0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; q_prev <= 2'b00;
    end else begin
      if (m_axi_awvalid && !m_axi_awready && !aw_got) begin
        if (aw_cnt >= aw_wait) begin m_axi_awready <= 1'b1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end else begin m_axi_awready <= 1'b0; aw_cnt <= 0; end
      if (m_axi_wvalid && !m_axi_wready && !w_got) begin
        if (w_cnt >= w_wait) begin m_axi_wready <= 1'b1; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end else begin m_axi_wready <= 1'b0; w_cnt <= 0; end
      if (m_axi_awvalid && m_axi_awready) aw_addr_q <= m_axi_awaddr;
      if (m_axi_wvalid && m_axi_wready) begin w_data_q <= m_axi_wdata; w_strb_q <= m_axi_wstrb; end
      aw_n   = aw_got | (m_axi_awvalid & m_axi_awready);
      w_n    = w_got  | (m_axi_wvalid & m_axi_wready);
      a_addr = aw_got ? aw_addr_q : m_axi_awaddr;
      a_data = w_got ? w_data_q : m_axi_wdata;
      a_strb = w_got ? w_strb_q : m_axi_wstrb;
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (ctrl_q[CTRL_ENABLE] && fwd(q_prev, {qa, qb})) pos_q <= pos_q + 32'd1;
      q_prev <= {qa, qb};
      if (aw_n && w_n && !b_hold && !m_axi_bvalid) begin
        m_axi_bvalid <= 1'b1;
        aw_got <= 1'b0; w_got <= 1'b0;
        if (a_addr == ENC_CTRL) begin
          for (int b = 0; b < 4; b++) if (a_strb[b]) ctrl_q[8*b +: 8] <= a_data[8*b +: 8];
          if (a_strb[0] && a_data[CTRL_CLR_POS]) pos_q <= 32'h0;
          m_axi_bresp <= RESP_OKAY;
        end else m_axi_bresp <= RESP_SLVERR;
      end else begin aw_got <= aw_n; w_got <= w_n; end
      if (m_axi_arvalid && !m_axi_arready && !ar_never && !m_axi_rvalid) begin
        if (ar_cnt >= ar_wait) begin m_axi_arready <= 1'b1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end else begin m_axi_arready <= 1'b0; ar_cnt <= 0; end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rresp  <= RESP_OKAY;
        case (m_axi_araddr)
          ENC_CTRL:     m_axi_rdata <= ctrl_q;
          ENC_STATUS:   m_axi_rdata <= {31'h0, ctrl_q[CTRL_ENABLE]};
          ENC_POSITION: m_axi_rdata <= pos_q;
          default: begin m_axi_rdata <= 32'h0; m_axi_rresp <= RESP_SLVERR; end
        endcase
      end
    end
  end

  // Channel monitors sampled away from the active edge.
  always @(negedge aclk) begin
    if (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid)) overlap_cnt++;
    if (m_axi_awvalid && !m_axi_wvalid) aw_only_cnt++;
    if (m_axi_arvalid) ar_hi_cnt++;
  end
  always @(posedge aclk) if (m_axi_bvalid && m_axi_bready) b_hs_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start_cmd(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) chk("cmd_ready_bound", 32'(cmd_ready), 32'd1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int lat);
    lat = 1;
    while (!rsp_valid && lat < budget) begin @(posedge aclk); #1; lat++; end
    if (!rsp_valid) chk("rsp_valid_bound", 32'(rsp_valid), 32'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge aclk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic quad_fwd(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk); #1;
      qidx = (qidx + 1) % 4;
      {qa, qb} = gray[qidx];
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    int lat;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}), 32'd0);
    chk("rst_rsp", {rsp_data[29:0], rsp_resp}, 32'd0);
    chk("rst_timeout", 32'(rsp_timeout), 32'd0);
    areset = 1'b0;
    @(posedge aclk); #1;

    // 1: zero-wait write
    start_cmd(1'b1, ENC_CTRL, 32'h0000_0001, 4'hF);
    chk("t1_aw_w_rise", 32'({m_axi_awvalid, m_axi_wvalid}), 32'd3);
    chk("t1_awaddr", m_axi_awaddr, ENC_CTRL);
    chk("t1_wdata", m_axi_wdata, 32'h0000_0001);
    wait_rsp(50, lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_resp", 32'(rsp_resp), 32'(RESP_OKAY));
    chk("t1_data", rsp_data, 32'h0);
    chk("t1_timeout", 32'(rsp_timeout), 32'd0);
    finish_rsp();

    // 2: W handshake 3 cycles before AW
    aw_wait = 3; aw_only_cnt = 0; b_hs_cnt = 0;
    start_cmd(1'b1, ENC_CTRL, 32'h0000_0001, 4'hF);
    wait_rsp(50, lat);
    chk("t2_latency", 32'(lat), 32'd7);
    chk("t2_aw_hold_cycles", 32'(aw_only_cnt), 32'd3);
    chk("t2_resp", 32'(rsp_resp), 32'(RESP_OKAY));
    finish_rsp();
    repeat (3) @(posedge aclk);
    #1;
    chk("t2_one_b", 32'(b_hs_cnt), 32'd1);
    aw_wait = 0;

    // 3: encoder position and status
    start_cmd(1'b1, ENC_CTRL, 32'h0000_0001, 4'hF);
    wait_rsp(50, lat);
    chk("t3_ctrl_resp", 32'(rsp_resp), 32'(RESP_OKAY));
    finish_rsp();
    quad_fwd(20);
    start_cmd(1'b0, ENC_POSITION, 32'h0, 4'h0);
    chk("t3_arvalid_rise", 32'(m_axi_arvalid), 32'd1);
    chk("t3_araddr", m_axi_araddr, ENC_POSITION);
    wait_rsp(50, lat);
    chk("t3_rd_latency", 32'(lat), 32'd4);
    chk("t3_position", rsp_data, 32'h0000_0014);
    chk("t3_pos_resp", 32'(rsp_resp), 32'(RESP_OKAY));
    finish_rsp();
    start_cmd(1'b0, ENC_STATUS, 32'h0, 4'h0);
    wait_rsp(50, lat);
    chk("t3_status", rsp_data, 32'h0000_0001);
    finish_rsp();

    // 4: error responses pass through; no read/write overlap
    start_cmd(1'b0, 32'h0000_00FF, 32'h0, 4'h0);
    wait_rsp(50, lat);
    chk("t4_rd_slverr", 32'(rsp_resp), 32'(RESP_SLVERR));
    finish_rsp();
    start_cmd(1'b1, ENC_STATUS, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(50, lat);
    chk("t4_wr_slverr", 32'(rsp_resp), 32'(RESP_SLVERR));
    chk("t4_wr_data", rsp_data, 32'h0);
    finish_rsp();
    chk("t4_no_overlap", 32'(overlap_cnt), 32'd0);

    // 5: response back-pressure
    start_cmd(1'b0, ENC_POSITION, 32'h0, 4'h0);
    wait_rsp(50, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_data", rsp_data, 32'h0000_0014);
      chk("t5_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_write = 1'b1; cmd_addr = ENC_CTRL; cmd_wdata = 32'h0; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    chk("t5_cmd_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge aclk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("t5_rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("t5_cmd_ready_up", 32'(cmd_ready), 32'd1);
    chk("t5_not_accepted", 32'(m_axi_awvalid), 32'd0);
    @(posedge aclk); #1;

    // 6: reset during WR_RESP
    b_hold = 1'b1;
    start_cmd(1'b1, ENC_CTRL, 32'h0000_0003, 4'hF);
    begin
      int n = 0;
      while (!m_axi_bready && n < 20) begin @(posedge aclk); #1; n++; end
    end
    chk("t6_in_wr_resp", 32'(m_axi_bready), 32'd1);
    #2 areset = 1'b1;
    #1;
    chk("t6_rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}), 32'd0);
    chk("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    b_hold = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    chk("t6_post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    start_cmd(1'b0, ENC_CTRL, 32'h0, 4'h0);
    wait_rsp(50, lat);
    chk("t6_post_read", rsp_data, 32'h0);
    chk("t6_post_latency", 32'(lat), 32'd4);
    finish_rsp();

`ifdef AXIL_TIMEOUT_EN
    // 6b: AR never accepted -> abort after 255 cycles of arvalid
    ar_never = 1'b1; ar_hi_cnt = 0;
    start_cmd(1'b0, ENC_CTRL, 32'h0, 4'h0);
    wait_rsp(400, lat);
    chk("t6_to_arvalid_cycles", 32'(ar_hi_cnt), 32'd255);
    chk("t6_to_latency", 32'(lat), 32'd256);
    chk("t6_to_flag", 32'(rsp_timeout), 32'd1);
    chk("t6_to_resp", 32'(rsp_resp), 32'(RESP_DECERR));
    chk("t6_to_data", rsp_data, 32'h0);
    chk("t6_to_arvalid_low", 32'(m_axi_arvalid), 32'd0);
    finish_rsp();
    ar_never = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
